// File: rtl/neuro_cfg_pkg.sv
// ---------------------------------------------------------------------------
// neuro_cfg_pkg : opcodes, packet lengths and FSM encoding for the streamer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package neuro_cfg_pkg;

  localparam logic [7:0] OP_WEIGHT = 8'hFF;
  localparam logic [7:0] OP_REGSET = 8'hFE;
  localparam logic [7:0] OP_MODE   = 8'hFD;

  localparam logic [3:0] LEN_WEIGHT = 4'd10;
  localparam logic [3:0] LEN_REGSET = 4'd8;
  localparam logic [3:0] LEN_MODE   = 4'd4;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_EMIT  = 3'd1;
  localparam state_t ST_GAP   = 3'd2;
  localparam state_t ST_FETCH = 3'd3;
  localparam state_t ST_PGAP  = 3'd4;

  // Zero marks an unknown opcode.
  function automatic logic [3:0] op_len(input logic [7:0] op);
    case (op)
      OP_WEIGHT: return LEN_WEIGHT;
      OP_REGSET: return LEN_REGSET;
      OP_MODE:   return LEN_MODE;
      default:   return 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_word_fifo.sv
// ---------------------------------------------------------------------------
// cfg_word_fifo : synchronous DEPTH x WIDTH FIFO with show-ahead read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cfg_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  // A write into a full FIFO is legal only when a read frees the slot.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/neuron_cfg_streamer.sv
// ---------------------------------------------------------------------------
// neuron_cfg_streamer : buffers 32-bit config words, streams byte packets
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module neuron_cfg_streamer
  import neuro_cfg_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BYTE_GAP = 3,
  parameter int unsigned PKT_GAP  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  data,
  output logic        load_data,
  output logic        busy,
  output logic        pkt_done,
  output logic        err
);

  localparam int unsigned GAP_MAX = (BYTE_GAP > PKT_GAP) ? BYTE_GAP : PKT_GAP;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] BYTE_GAP_LAST = GAP_W'(BYTE_GAP - 1);
  localparam logic [GAP_W-1:0] PKT_GAP_LAST  = GAP_W'(PKT_GAP - 1);

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]       len_q, len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             pkt_done_q, pkt_done_d;
  logic             err_q, err_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]      fifo_rdata;
  logic [3:0]       head_len;
  logic [7:0]       cur_byte;
  logic             take_word, next_byte;

  assign fifo_push = in_valid && !fifo_full;
  assign head_len  = op_len(fifo_rdata[7:0]);
  assign cur_byte  = word_q[{byte_idx_q, 3'b000} +: 8];

  cfg_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_push),
    .wr_data (in_word),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      data_q     <= '0;
      byte_idx_q <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      gap_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_done_d = 1'b0;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    take_word  = 1'b0;
    next_byte  = 1'b0;

    case (state_q)
      // Holding off while pkt_done is high keeps two cycles before the next strobe.
      ST_IDLE: begin
        if (!fifo_empty && !pkt_done_q) begin
          if (head_len != 4'd0) begin
            take_word = 1'b1;
            len_d     = head_len;
          end else begin
            fifo_pop = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q != BYTE_GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else if (byte_cnt_q == len_q) begin
          state_d   = ST_PGAP;
          gap_cnt_d = '0;
        end else if (byte_idx_q != 2'd0) begin
          next_byte = 1'b1;
        end else if (!fifo_empty) begin
          // Fetching here rather than via FETCH keeps byte spacing across words.
          take_word = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          take_word = 1'b1;
        end
      end
      ST_PGAP: begin
        if (gap_cnt_q != PKT_GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
          byte_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_word) begin
      fifo_pop   = 1'b1;
      word_d     = fifo_rdata;
      data_d     = fifo_rdata[7:0];
      byte_idx_d = 2'd1;
      byte_cnt_d = byte_cnt_q + 4'd1;
      state_d    = ST_EMIT;
    end
    if (next_byte) begin
      data_d     = cur_byte;
      byte_idx_d = byte_idx_q + 2'd1;
      byte_cnt_d = byte_cnt_q + 4'd1;
      state_d    = ST_EMIT;
    end
  end

  always_comb begin
    in_ready  = !fifo_full;
    data      = data_q;
    load_data = (state_q == ST_EMIT);
    busy      = (state_q != ST_IDLE) || !fifo_empty;
    pkt_done  = pkt_done_q;
    err       = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_cfg_streamer.sv
// ---------------------------------------------------------------------------
// tb_neuron_cfg_streamer : scoreboard bench with packet-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_neuron_cfg_streamer;

  localparam int BYTE_GAP = 3;
  localparam int PKT_GAP  = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data;
  logic        load_data;
  logic        busy;
  logic        pkt_done;
  logic        err;

  neuron_cfg_streamer #(
    .DEPTH    (4),
    .BYTE_GAP (BYTE_GAP),
    .PKT_GAP  (PKT_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .load_data (load_data),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         word_first;
    bit         pkt_first;
  } exp_byte_t;

  exp_byte_t exp_q[$];
  int        exp_pkt_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int  words_left = 0, bytes_left = 0, cur_len = 0;
  bit  pkt_first_pending = 0;
  bit  exp_err = 0;
  int  strobe_cnt = 0, last_strobe = 0, last_done = 0, pkt_bytes_seen = 0;
  bit  have_done = 0;
  int  last_acc = 0;
  bit  saw_stall = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int pkt_len(input logic [7:0] op);
    case (op)
      8'hFF:   return 10;
      8'hFE:   return 8;
      8'hFD:   return 4;
      default: return 0;
    endcase
  endfunction

  // Reference model: parse the accepted word stream into expected bytes/packets.
  task automatic model_word(input logic [31:0] w);
    exp_byte_t e;
    if (words_left == 0) begin
      cur_len = pkt_len(w[7:0]);
      if (cur_len == 0) begin
        exp_err = 1'b1;
        return;
      end
      bytes_left        = cur_len;
      words_left        = (cur_len + 3) / 4;
      pkt_first_pending = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (bytes_left > 0) begin
        e.b          = w[8*k +: 8];
        e.word_first = (k == 0);
        e.pkt_first  = (k == 0) && pkt_first_pending;
        pkt_first_pending = 1'b0;
        exp_q.push_back(e);
        bytes_left--;
      end
    end
    words_left--;
    if (words_left == 0) exp_pkt_q.push_back(cur_len);
  endtask

  task automatic model_flush();
    exp_q.delete();
    exp_pkt_q.delete();
    words_left = 0;
    bytes_left = 0;
    exp_err = 1'b0;
    pkt_bytes_seen = 0;
    have_done = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [31:0] w);
    int t = 0;
    in_word  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      saw_stall = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      $display("FAIL push_timeout: in_ready stuck low, expected high within 2000 cycles");
    end else begin
      last_acc = cyc;
      model_word(w);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp_pkt_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d bytes %0d packets pending, expected 0", exp_q.size(), exp_pkt_q.size());
    end
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("err_flag", err, exp_err);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes or ends a packet.
  initial begin
    exp_byte_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_data = data;
        continue;
      end
      if (load_data) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: data %0h, expected no strobe", data);
        end else begin
          e = exp_q.pop_front();
          chk("byte_value", data, e.b);
          if (e.pkt_first) begin
            if (have_done) chk("pkt_to_strobe_min", (cyc - last_done) >= 2, 1);
          end else if (!e.word_first) begin
            chk("byte_spacing", cyc - last_strobe, BYTE_GAP + 1);
          end else begin
            chk("word_spacing_min", (cyc - last_strobe) >= BYTE_GAP + 1, 1);
          end
        end
        last_strobe = cyc;
        strobe_cnt++;
        pkt_bytes_seen++;
      end else begin
        chk("data_held", data, prev_data);
      end
      prev_data = data;
      if (pkt_done) begin
        if (exp_pkt_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pkt_done: pkt_done high, expected low");
        end else begin
          chk("pkt_byte_count", pkt_bytes_seen, exp_pkt_q.pop_front());
          chk("pkt_done_delay", cyc - last_strobe, 1 + BYTE_GAP + PKT_GAP);
        end
        pkt_bytes_seen = 0;
        last_done = cyc;
        have_done = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t, nw, len, sel;
    logic [31:0] w;

    rst_n = 1'b0; in_valid = 1'b0; in_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Weight packet
    push_word(32'h010138FF);
    push_word(32'h05040300);
    push_word(32'h00000000);
    drain();

    // Mode packet: first-byte latency
    s0 = strobe_cnt;
    push_word(32'h000001FD);
    t = 0;
    while (strobe_cnt == s0 && t < 50) begin @(negedge clk); t++; end
    chk("first_latency", last_strobe - last_acc, 2);
    drain();

    // Unknown opcode followed by a valid packet
    s0 = strobe_cnt;
    push_word(32'h12345678);
    repeat (6) @(negedge clk);
    chk("bad_op_err", err, 1);
    chk("bad_op_no_strobe", strobe_cnt - s0, 0);
    push_word(32'h000001FD);
    drain();

    // Back-to-back: three regset packets held on in_valid
    saw_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_word({24'h0A0B0C, 8'hFE} + (i << 8));
      push_word(32'h44332211 + i);
    end
    chk("backpressure_seen", saw_stall, 1);
    drain();

    // Underrun mid-packet
    s0 = strobe_cnt;
    push_word(32'h030201FE);
    repeat (20) @(negedge clk);
    chk("underrun_first_half", strobe_cnt - s0, 4);
    chk("underrun_busy", busy, 1);
    push_word(32'h07060504);
    drain();
    chk("underrun_total", strobe_cnt - s0, 8);

    // Asynchronous reset mid-packet
    push_word(32'hAABBCCFF);
    push_word(32'h11223344);
    push_word(32'h55667788);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_load_data", load_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data, 0);
    chk("midrst_in_ready", in_ready, 1);
    model_flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(32'h5A6B7CFD);
    drain();

    // Randomized packets with occasional bad opcodes and idle gaps
    for (int p = 0; p < 30; p++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       len = 0;
        1, 2, 3: len = 10;
        4, 5, 6: len = 8;
        default: len = 4;
      endcase
      nw = (len == 0) ? 1 : (len + 3) / 4;
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        if (k == 0) begin
          case (len)
            10:      w[7:0] = 8'hFF;
            8:       w[7:0] = 8'hFE;
            4:       w[7:0] = 8'hFD;
            default: w[7:0] = 8'($urandom_range(0, 252));
          endcase
        end
        push_word(w);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(5, 30)) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neuron_cfg_streamer.md
# neuron_cfg_streamer

Upstream feeder for the neuron's configuration port. It accepts 32-bit configuration words from the SoC bus side through a valid/ready handshake and buffers them in a small FIFO. It splits the words into the neuron's byte-serial packet protocol and drives `data[7:0]` with a one-cycle `load_data` strobe per byte. Inter-byte and inter-packet gaps are enforced so the neuron controller always sees a stable byte before each strobe.

## Interface
- `DEPTH`, 4: word FIFO depth (power of two, ≥2).
- `BYTE_GAP`, 3: idle cycles after each `load_data` pulse.
- `PKT_GAP`, 5: idle cycles after the last byte of a packet.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low; one clock, all state in the `clk` domain.
- `in_word` in 32: config word, bytes sent little-endian (bits [7:0] first).
- `in_valid` in 1: `in_word` valid.
- `in_ready` out 1: FIFO not full; a word is accepted when `in_valid && in_ready` at a rising edge.
- `data` out 8: byte to neuron, held stable until the next byte.
- `load_data` out 1: one-cycle strobe, `data` valid.
- `busy` out 1: a packet is in flight or the FIFO is non-empty.
- `pkt_done` out 1: one-cycle pulse after the final gap of each packet.
- `err` out 1: sticky unknown-opcode flag, cleared only by reset.

## Operation
- Packet length comes from the opcode, which is the first byte of a packet word:
  - 0xFF (weight) = 10 bytes.
  - 0xFE (register set) = 8 bytes.
  - 0xFD (working mode) = 4 bytes.
- Length includes the opcode, the control bytes and the terminator. Byte content is passed through unmodified.
- A packet occupies ceil(len/4) words. Unused upper bytes of its last word are discarded, so the next packet always starts at byte 0 of a fresh word.
- Unknown opcode: the whole word is dropped, `err` is set and the FSM returns to IDLE. No `load_data` pulse is issued.
- FSM states:
  - IDLE: FIFO non-empty → pop the word, latch the opcode length, go to EMIT.
  - EMIT: drive the byte, assert `load_data`, increment `byte_cnt`, go to GAP.
  - GAP: count `BYTE_GAP` cycles. If `byte_cnt == len`, go to PGAP. Otherwise go to EMIT if the current word still has bytes, or to FETCH if it is exhausted.
  - FETCH: wait while the FIFO is empty (underrun stalls; `data` is held and no strobe is issued). Then pop the word and go to EMIT.
  - PGAP: count `PKT_GAP` cycles, pulse `pkt_done`, go to IDLE.
- Counters: byte index 2 bits (wraps 3→0 at the word boundary), `byte_cnt` 4 bits, gap counter sized to max(`BYTE_GAP`, `PKT_GAP`).
- Push and pop in the same cycle on a full FIFO is allowed: the occupancy is unchanged and `in_ready` is not asserted that cycle.

## Timing
- Reset values: `data` = 0, `load_data` = 0, `busy` = 0, `pkt_done` = 0, `err` = 0, FSM = IDLE, FIFO empty. `in_ready` = 1 during and after reset.
- First-byte latency: a word accepted at edge N gives `load_data` high in cycle N+2 (FIFO write at N, IDLE pops at N+1, EMIT at N+2).
- Byte spacing: consecutive `load_data` pulses are exactly `BYTE_GAP`+1 cycles apart within a packet, word boundaries included, as long as the FIFO is not empty.
- Packet spacing: `pkt_done` goes high `PKT_GAP` cycles after the last GAP ends. The next packet's first strobe comes at the earliest 2 cycles after `pkt_done`.
- `data` changes only in the cycle its `load_data` is asserted and is held afterwards.
- Reset asserted mid-packet: all outputs return to reset values immediately (asynchronously), and FIFO contents are lost.

## Structure
- Shared package `neuro_cfg_pkg`:
  - Opcode constants `OP_WEIGHT` = 0xFF, `OP_REGSET` = 0xFE, `OP_MODE` = 0xFD.
  - Length constants 10, 8 and 4.
  - FSM state encoding.
- One sub-module, `cfg_word_fifo`: a synchronous FIFO of `DEPTH` × 32 with `full`/`empty` and show-ahead read.

## Test plan
- Weight packet: push 0x010138FF, 0x05040300, 0x00000000 → 10 strobes with bytes FF,38,01,01,00,03,04,05,00,00 spaced 4 cycles apart, then one `pkt_done`.
- Mode packet 0x000001FD → bytes FD,01,00,00. First strobe 2 cycles after acceptance, `busy` falls after PGAP.
- Bad opcode 0x12345678 followed by 0x000001FD → `err` = 1, no strobe for the bad word, then the mode packet is streamed normally.
- Back-to-back: push 6 words while holding `in_valid` → `in_ready` drops when 4 are buffered, and all bytes still arrive in order with no loss.
- Underrun: push only word 0 of an FE packet, wait 20 cycles, push word 1 → exactly 4 strobes, then a stall with `data` held, then the remaining 4 strobes.
- Pull `rst_n` low mid-packet → `load_data`, `busy` and `data` go to 0 immediately. After release, a new packet streams correctly from byte 0.
